sram_row_streamer: RTL and testbench

- Read-side sequencer that sits directly upstream of the row/k SRAM wrapper. It drives that wrapper's row/k read port.
- Sweeps one row from k=0 to k=len-1, collecting the returned words.
- Emits the words as a valid/ready stream with a last flag.
- Uses credit-based issue into a small skid FIFO, so downstream backpressure never drops SRAM read data.

---
 rtl/sram_row_streamer.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_row_streamer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_row_streamer.sv
// rtl/sram_row_streamer.sv - row/k SRAM read sequencer streaming one row through a credit-controlled skid FIFO
// Optional feature macro: SRAM_ROW_STREAMER_STALL_CNT_EN adds output stall_cnt[31:0].
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, row, len            job request (sampled in IDLE only)
//   busy, done, err            job status; done/err are one-cycle pulses
//   mem_en/re/we, mem_row/k    SRAM read port (registered), mem_rdata/mem_rvalid response
//   m_valid/ready/data/k/last  output word stream
module sram_row_streamer #(
    parameter int M          = 8,
    parameter int KMAX       = 1024,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
    parameter int K_W        = (KMAX <= 1) ? 1 : $clog2(KMAX),
    parameter int LEN_W      = $clog2(KMAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  row,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ROW_W-1:0]  mem_row,
    output logic [K_W-1:0]    mem_k,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [K_W-1:0]    m_k,
    output logic              m_last
`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int          PTR_W  = $clog2(FIFO_DEPTH);
    localparam int          CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] KMAX_U = 32'(KMAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [LEN_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               err_flag_q, err_flag_d;
    logic               mem_en_q, mem_en_d;
    logic [K_W-1:0]     mem_k_q, mem_k_d;
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [K_W-1:0]     fifo_k_q [FIFO_DEPTH];
    logic [K_W-1:0]     fifo_k_d [FIFO_DEPTH];
    logic               fifo_last_q [FIFO_DEPTH];
    logic               fifo_last_d [FIFO_DEPTH];

    logic len_ok, credit_ok, issue, push, pop;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        len_d         = len_q;
        issued_d      = issued_q;
        ret_cnt_d     = ret_cnt_q;
        err_flag_d    = err_flag_q;
        mem_k_d       = mem_k_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_data_d   = fifo_data_q;
        fifo_k_d      = fifo_k_q;
        fifo_last_d   = fifo_last_q;

        len_ok    = (len != '0) && (32'(len) <= KMAX_U);
        // Credit uses registered counts only, so a pop frees a slot one cycle later.
        credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(FIFO_DEPTH);
        issue     = (state_q == RUN) && (issued_q < len_q) && credit_ok;
        // Responses with nothing outstanding are protocol errors and are dropped.
        push      = mem_rvalid && (outstanding_q != '0);
        pop       = (fifo_cnt_q != '0) && m_ready;

        mem_en_d  = issue;
        if (issue) begin
            mem_k_d  = issued_q[K_W-1:0];
            issued_d = issued_q + LEN_W'(1);
        end

        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(push);
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_k_d[wr_ptr_q]    = ret_cnt_q[K_W-1:0];
            fifo_last_d[wr_ptr_q] = (ret_cnt_q == len_q - LEN_W'(1));
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            ret_cnt_d             = ret_cnt_q + LEN_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        row_d      = row;
                        len_d      = len;
                        issued_d   = '0;
                        ret_cnt_d  = '0;
                        err_flag_d = 1'b0;
                        state_d    = RUN;
                    end else begin
                        err_flag_d = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            RUN: begin
                if (issue && (issued_q == len_q - LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finish in the cycle of the final handshake so done follows it directly.
                if ((outstanding_q == '0) &&
                    ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mem_rvalid && (outstanding_q == '0) && (state_q != IDLE)) begin
            err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            ret_cnt_q     <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_flag_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_k_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_k_q[i]    <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            ret_cnt_q     <= ret_cnt_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_flag_q    <= err_flag_d;
            mem_en_q      <= mem_en_d;
            mem_k_q       <= mem_k_d;
            fifo_data_q   <= fifo_data_d;
            fifo_k_q      <= fifo_k_d;
            fifo_last_q   <= fifo_last_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign err     = (state_q == FIN) && err_flag_q;
    assign mem_en  = mem_en_q;
    assign mem_re  = mem_en_q;
    assign mem_we  = 1'b0;
    assign mem_row = row_q;
    assign mem_k   = mem_k_q;
    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_k     = fifo_k_q[rd_ptr_q];
    assign m_last  = m_valid && fifo_last_q[rd_ptr_q];

`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (busy && m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_row_streamer.sv
// tb/tb_sram_row_streamer.sv - self-checking bench for sram_row_streamer
`timescale 1ns/1ps
module tb_sram_row_streamer;
    localparam int M = 8, KMAX = 1024, DATA_W = 32, FD = 4;
    localparam int ROW_W = 3, K_W = 10, LEN_W = 11;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [ROW_W-1:0] row = '0;
    logic [LEN_W-1:0] len = '0;
    logic busy, done, err, mem_en, mem_re, mem_we, m_valid, m_last;
    logic [ROW_W-1:0] mem_row;
    logic [K_W-1:0] mem_k, m_k;
    logic [DATA_W-1:0] mem_rdata = '0, m_data;
    logic mem_rvalid = 1'b0;
`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    sram_row_streamer #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row(row), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_en(mem_en), .mem_re(mem_re), .mem_we(mem_we), .mem_row(mem_row), .mem_k(mem_k),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_k(m_k), .m_last(m_last)
`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int r, input int k);
        return DATA_W'(r * KMAX + k);
    endfunction

    // SRAM model: one-cycle read latency, in-order responses.
    logic pend = 1'b0;
    logic [DATA_W-1:0] pend_data = '0;
    initial forever begin
        @(posedge clk); #1;
        mem_rvalid = pend;
        mem_rdata  = pend_data;
        pend       = mem_en;
        pend_data  = word(int'(mem_row), int'(mem_k));
    end

    typedef struct { logic [DATA_W-1:0] d; int k; bit last; } beat_t;
    beat_t beats[$];
    int n_en, n_pop, done_cnt, err_cnt, done_cyc, last_hs, credit_viol, stable_viol;
    int en_in_stall, valid_seen, stall_obs, busy_after, strobe_viol, busy_first;
    logic [31:0] stall_hw;
    bit timed_out;

    task automatic run_job(input int r, input int l, input int mode, input int stall_n,
                           input int inject_at, input int abort_beats);
        int cyc;
        bit prev_stall, got_done;
        beat_t prev;
        beats.delete();
        n_en = 0; n_pop = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; last_hs = -1;
        credit_viol = 0; stable_viol = 0; en_in_stall = 0; valid_seen = 0; stall_obs = 0;
        busy_after = 0; strobe_viol = 0; busy_first = 0; stall_hw = '0;
        timed_out = 1'b1; prev_stall = 1'b0; got_done = 1'b0; prev = '{'0, 0, 1'b0};
        row = ROW_W'(r); len = LEN_W'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (cyc >= stall_n);
            endcase
            if (cyc == inject_at) begin
                start = 1'b1; row = ROW_W'(1); len = LEN_W'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) busy_first = int'(busy);
            if ((mem_re !== mem_en) || (mem_we !== 1'b0)) strobe_viol++;
            if (mem_en) begin
                n_en++;
                if (cyc < stall_n) en_in_stall++;
            end
            if (n_en - n_pop > FD) credit_viol++;
            if (prev_stall && (!m_valid || m_data !== prev.d || int'(m_k) != prev.k || m_last !== prev.last))
                stable_viol++;
            if (m_valid) valid_seen++;
            if (busy && m_valid && !m_ready) stall_obs++;
            if (m_valid && m_ready) begin
                beats.push_back('{m_data, int'(m_k), m_last});
                n_pop++;
                last_hs = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev = '{m_data, int'(m_k), m_last};
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (!got_done) begin
                    got_done = 1'b1; done_cyc = cyc; timed_out = 1'b0;
`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
                    stall_hw = stall_cnt;
`endif
                end
            end
            if (got_done && cyc > done_cyc && busy) busy_after++;
            if (abort_beats > 0 && beats.size() == abort_beats) begin
                timed_out = 1'b0;
                return;
            end
            if (got_done && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_job(input string tag, input int r, input int l, input int mode,
                             input int stall_n, input bit exp_err, input int exp_n);
        int bad_beats = 0;
        chk({tag, " timeout"}, 64'(timed_out), 0);
        chk({tag, " busy_first"}, 64'(busy_first), 1);
        chk({tag, " done_cnt"}, 64'(done_cnt), 1);
        chk({tag, " err"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, " mem_en"}, 64'(n_en), 64'(exp_n));
        chk({tag, " beats"}, 64'(beats.size()), 64'(exp_n));
        foreach (beats[i])
            if (beats[i].d !== word(r, i) || beats[i].k != i || beats[i].last != (i == l - 1))
                bad_beats++;
        chk({tag, " beat_data"}, 64'(bad_beats), 0);
        chk({tag, " busy_after_done"}, 64'(busy_after), 0);
        chk({tag, " credit"}, 64'(credit_viol), 0);
        chk({tag, " stable"}, 64'(stable_viol), 0);
        chk({tag, " strobes"}, 64'(strobe_viol), 0);
        if (exp_err) begin
            chk({tag, " done_cyc"}, 64'(done_cyc), 0);
            chk({tag, " no_valid"}, 64'(valid_seen), 0);
        end else begin
            chk({tag, " done_after_hs"}, 64'(done_cyc), 64'(last_hs + 1));
`ifdef SRAM_ROW_STREAMER_STALL_CNT_EN
            chk({tag, " stall_cnt"}, 64'(stall_hw), 64'(stall_obs));
`endif
        end
        if (mode == 3) chk({tag, " en_in_stall"}, 64'(en_in_stall), 64'((exp_n < FD) ? exp_n : FD));
    endtask

    typedef struct { int r; int l; int mode; int stall_n; bit exp_err; int exp_n; } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{3, 8,        0, 0,  1'b0, 8};
        vecs[1] = '{5, 16,       1, 0,  1'b0, 16};
        vecs[2] = '{2, 10,       3, 20, 1'b0, 10};
        vecs[3] = '{0, 0,        0, 0,  1'b1, 0};
        vecs[4] = '{7, KMAX + 1, 0, 0,  1'b1, 0};
        vecs[5] = '{7, 1,        0, 0,  1'b0, 1};
        vecs[6] = '{1, 4,        2, 0,  1'b0, 4};
        vecs[7] = '{6, KMAX,     0, 0,  1'b0, KMAX};

        #1;
        chk("reset_ctrl", {busy, done, err, mem_en, mem_re, mem_we, m_valid, m_last}, 0);
        chk("reset_data", {mem_row, mem_k, m_data, m_k}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_job(vecs[i].r, vecs[i].l, vecs[i].mode, vecs[i].stall_n, -1, 0);
            check_job($sformatf("vec%0d", i), vecs[i].r, vecs[i].l, vecs[i].mode,
                      vecs[i].stall_n, vecs[i].exp_err, vecs[i].exp_n);
        end

        // Start while busy must be ignored.
        run_job(0, 12, 0, 0, 5, 0);
        check_job("start_busy", 0, 12, 0, 0, 1'b0, 12);

        // Reset mid-job, then a spurious response right after release.
        run_job(4, 32, 0, 0, -1, 5);
        chk("abort_beats", 64'(beats.size()), 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, err, mem_en, mem_re, m_valid, m_last}, 0);
        chk("midrst_data", {mem_row, mem_k, m_data, m_k}, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        chk("spurious_drop", {m_valid, busy}, 0);
        run_job(2, 2, 0, 0, -1, 0);
        check_job("after_rst", 2, 2, 0, 0, 1'b0, 2);

        // Randomized jobs against the reference model.
        for (int i = 0; i < 12; i++) begin
            int r, l;
            bit bad;
            r = $urandom_range(0, M - 1);
            l = ((i % 5) == 4) ? 0 : $urandom_range(1, 40);
            bad = (l == 0) || (l > KMAX);
            run_job(r, l, 2, 0, -1, 0);
            check_job($sformatf("rand%0d", i), r, l, 2, 0, bad, bad ? 0 : l);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
